// File: rtl/bus_debug_bridge_pkg.sv
// Shared command/reply codes, FSM state encoding and bus defaults for the debug bridge.
package bus_debug_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    BUS   = 3'd3,
    REPLY = 3'd4
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] REPLY_ACK = 8'h06;
  localparam logic [7:0] REPLY_NAK = 8'h15;

  localparam int unsigned DEFAULT_BUS_TIMEOUT   = 255;
  localparam logic [2:0]  DEFAULT_ACCESS_OPTION = 3'b010;

  // Index of the final byte of a 32-bit word shifted MSB first.
  localparam logic [1:0] LAST_WORD_BYTE = 2'd3;

  function automatic logic is_command(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/bus_debug_bridge.sv
// Byte-stream debug bridge: decodes 'W'/'R' commands into single 32-bit bus
// transfers and streams back an ACK/NAK byte or the 4 read-data bytes.
module bus_debug_bridge
  import bus_debug_bridge_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT   = DEFAULT_BUS_TIMEOUT,
  parameter logic [2:0]  ACCESS_OPTION = DEFAULT_ACCESS_OPTION
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic [2:0]  option,
  input  logic        memory_response
);

  localparam int unsigned TMO_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUS_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              cmd_write_q, cmd_write_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       reply_q, reply_d;
  logic [1:0]        reply_last_q, reply_last_d;
  logic              in_hs, out_hs;

  assign in_ready     = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
  assign out_valid    = (state_q == REPLY);
  assign out_data     = reply_q[31:24];
  assign memory_read  = (state_q == BUS) && !cmd_write_q;
  assign memory_write = (state_q == BUS) && cmd_write_q;
  assign address      = addr_q;
  assign write_data   = wdata_q;
  assign option       = ACCESS_OPTION;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    cmd_write_d  = cmd_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    reply_d      = reply_q;
    reply_last_d = reply_last_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          cnt_d = 2'd0;
          tmo_d = '0;
          if (is_command(in_data)) begin
            cmd_write_d = (in_data == CMD_WRITE);
            state_d     = ADDR;
          end else begin
            reply_d      = {REPLY_NAK, 24'h0};
            reply_last_d = 2'd0;
            state_d      = REPLY;
          end
        end
      end
      ADDR: begin
        if (in_hs) begin
          addr_d = {addr_q[23:0], in_data};
          if (cnt_q == LAST_WORD_BYTE) begin
            cnt_d   = 2'd0;
            tmo_d   = '0;
            state_d = cmd_write_q ? DATA : BUS;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      DATA: begin
        if (in_hs) begin
          wdata_d = {wdata_q[23:0], in_data};
          if (cnt_q == LAST_WORD_BYTE) begin
            cnt_d   = 2'd0;
            tmo_d   = '0;
            state_d = BUS;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      BUS: begin
        // A response on the final allowed cycle still wins over the timeout.
        if (memory_response) begin
          cnt_d   = 2'd0;
          tmo_d   = '0;
          state_d = REPLY;
          if (cmd_write_q) begin
            reply_d      = {REPLY_ACK, 24'h0};
            reply_last_d = 2'd0;
          end else begin
            reply_d      = read_data;
            reply_last_d = LAST_WORD_BYTE;
          end
        end else if (tmo_q == TMO_LAST) begin
          cnt_d        = 2'd0;
          tmo_d        = '0;
          reply_d      = {REPLY_NAK, 24'h0};
          reply_last_d = 2'd0;
          state_d      = REPLY;
        end else if (tmo_q != {TMO_W{1'b1}}) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      REPLY: begin
        if (out_hs) begin
          if (cnt_q == reply_last_q) begin
            cnt_d   = 2'd0;
            tmo_d   = '0;
            reply_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            reply_d = {reply_q[23:0], 8'h00};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      tmo_q        <= '0;
      cmd_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      reply_q      <= '0;
      reply_last_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      cmd_write_q  <= cmd_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      reply_q      <= reply_d;
      reply_last_q <= reply_last_d;
    end
  end

endmodule

// File: tb/tb_bus_debug_bridge.sv
// Self-checking bench for bus_debug_bridge: directed scenarios plus randomized
// command streams checked against a transaction-level reference model.
module tb_bus_debug_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [2:0]  option;
  logic        memory_response;

  int checks = 0;
  int errors = 0;

  bus_debug_bridge #(.BUS_TIMEOUT(TMO), .ACCESS_OPTION(3'b010)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .memory_read(memory_read), .memory_write(memory_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .option(option), .memory_response(memory_response)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int k = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Drain the reply stream, checking hold-while-stalled and that no bus request is active.
  task automatic collectReply(input logic [7:0] expQ[$], input bit bp);
    logic [7:0] got[$];
    logic       prevStall = 1'b0;
    logic [7:0] prevData = 8'h00;
    int         cyc = 0;
    while (got.size() < expQ.size() && cyc < 100) begin
      checkOutput("no_req_in_reply", {31'd0, memory_read | memory_write}, 32'd0);
      if (prevStall) begin
        checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_data", {24'd0, out_data}, {24'd0, prevData});
      end
      out_ready = (bp && cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      if (out_valid && out_ready) got.push_back(out_data);
      prevStall = out_valid && !out_ready;
      prevData  = out_data;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("reply_len", got.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < got.size(); i++)
      checkOutput("reply_byte", {24'd0, got[i]}, {24'd0, expQ[i]});
    checkOutput("idle_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // respAt: request cycle (1-based) in which the responder answers; 0 = silent.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                               input int respAt, input logic [31:0] rdata, input bit bp);
    bit         isW = (cmd == 8'h57);
    bit         isR = (cmd == 8'h52);
    bit         answered = (respAt >= 1 && respAt <= TMO);
    int         expLen;
    int         n = 0;
    logic [7:0] expQ[$];
    if (!(isW || isR)) begin
      expQ.push_back(8'h15);
      expLen = 0;
    end else begin
      expLen = answered ? respAt : TMO;
      if (!answered) expQ.push_back(8'h15);
      else if (isW) expQ.push_back(8'h06);
      else for (int i = 3; i >= 0; i--) expQ.push_back(rdata[i*8 +: 8]);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    sendByte(cmd);
    if (isW || isR) for (int i = 3; i >= 0; i--) sendByte(addr[i*8 +: 8]);
    if (isW) for (int i = 3; i >= 0; i--) sendByte(wdata[i*8 +: 8]);
    for (int cyc = 0; cyc < TMO + 4; cyc++) begin
      if (!(memory_read || memory_write)) break;
      n++;
      checkOutput("req_type", {30'd0, memory_write, memory_read}, isW ? 32'd2 : 32'd1);
      checkOutput("req_address", address, addr);
      if (isW) checkOutput("req_wdata", write_data, wdata);
      checkOutput("req_option", {29'd0, option}, 32'd2);
      memory_response = (n == respAt);
      read_data       = (n == respAt) ? rdata : $urandom;
      @(negedge clk);
      memory_response = 1'b0;
    end
    checkOutput("req_cycles", n, expLen);
    collectReply(expQ, bp);
  endtask

  task automatic resetMidBus();
    int n = 0;
    sendByte(8'h52);
    for (int i = 0; i < 4; i++) sendByte(8'($urandom));
    while ((memory_read || memory_write) && n < 2) begin
      n++;
      if (n < 2) @(negedge clk);
    end
    checkOutput("rst_reached_2nd_req", n, 2);
    reset = 1'b1;
    @(negedge clk);
    reset           = 1'b0;
    memory_response = 1'b1;
    read_data       = $urandom;
    checkOutput("rst_mem_read", {31'd0, memory_read}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_address", address, 32'd0);
    @(negedge clk);
    memory_response = 1'b0;
    out_ready       = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("rst_no_reply", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_no_req", {31'd0, memory_read | memory_write}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    in_data         = 8'h00;
    in_valid        = 1'b0;
    out_ready       = 1'b0;
    read_data       = 32'h0;
    memory_response = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_mem_read", {31'd0, memory_read}, 32'd0);
    checkOutput("reset_mem_write", {31'd0, memory_write}, 32'd0);
    checkOutput("reset_address", address, 32'd0);
    checkOutput("reset_wdata", write_data, 32'd0);
    checkOutput("reset_out_data", {24'd0, out_data}, 32'd0);
    checkOutput("reset_option", {29'd0, option}, 32'd2);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
    applyStimulus(8'h52, 32'h0000_1000, 32'h0, 1, 32'h1234_5678, 1'b0);
    applyStimulus(8'h41, 32'h0, 32'h0, 1, 32'h0, 1'b0);
    applyStimulus(8'h52, 32'hA5A5_0004, 32'h0, 3, 32'h0BAD_F00D, 1'b0);
    applyStimulus(8'h52, 32'h0000_2000, 32'h0, 0, 32'h0, 1'b0);
    applyStimulus(8'h57, 32'h0000_3000, 32'h1111_2222, 0, 32'h0, 1'b0);
    applyStimulus(8'h52, 32'h0000_4000, 32'h0, TMO, 32'hCAFE_F00D, 1'b0);
    applyStimulus(8'h52, 32'h0000_5000, 32'h0, 4, 32'h8899_AABB, 1'b1);
    resetMidBus();
    applyStimulus(8'h52, 32'h0000_6000, 32'h0, 2, 32'h0102_0304, 1'b0);

    for (int t = 0; t < 25; t++) begin
      logic [7:0] cmd;
      int sel = $urandom_range(0, 2);
      cmd = (sel == 0) ? 8'h57 : (sel == 1) ? 8'h52 : 8'($urandom);
      if (sel == 2 && (cmd == 8'h57 || cmd == 8'h52)) cmd = 8'h00;
      applyStimulus(cmd, $urandom, $urandom, $urandom_range(0, TMO + 2), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
